// File: rtl/nd_int_pkg.sv
// Shared interrupt-system definitions: level width, sequencer states, "no pending" level.
package nd_int_pkg;

  localparam int unsigned LVL_W = 4;

  typedef logic [LVL_W-1:0] lvl_t;

  // Level 0 doubles as the encoder's "nothing pending" result
  localparam lvl_t LVL_NONE = '0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    CMP    = 3'd3,
    REQ    = 3'd4
  } seq_state_e;

endpackage

// File: rtl/int_level_seq.sv
// Interrupt level sequencer: samples the PID/PIE priority encoder (PILKL strobe)
// once writes have settled, and requests a program level change from the
// microsequencer through a req/ack handshake at instruction boundaries.
module int_level_seq
  import nd_int_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MCL,
  input  logic             PONI,
  input  logic [LVL_W-1:0] PK,
  input  logic             pid_pie_wr,
  input  logic             ibnd,
  input  logic             lchg_ack,
  output logic             PILKL,
  output logic             lchg_req,
  output logic [LVL_W-1:0] new_lvl,
  output logic [LVL_W-1:0] old_lvl,
  output logic [LVL_W-1:0] cur_lvl,
  output logic             busy
);

  localparam int unsigned     CNT_W      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = (SETTLE_CYC == 0) ? '0 : CNT_W'(SETTLE_CYC - 1);

  seq_state_e       state;
  seq_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             dirty;
  logic             poni_q;
  logic             poni_rise;

  assign poni_rise = PONI && !poni_q;

  // Next-state decode; the request, once raised, only ends on ack
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (dirty && PONI && ibnd) begin
          state_nxt = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
        end
      end
      SETTLE: begin
        if (!PONI) begin
          state_nxt = IDLE;
        end else if (pid_pie_wr) begin
          state_nxt = SETTLE;
        end else if (cnt == '0) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: state_nxt = CMP;
      CMP:    state_nxt = (new_lvl == cur_lvl) ? IDLE : REQ;
      REQ: begin
        if (lchg_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, settle counter, dirty flag, level registers and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      dirty    <= 1'b0;
      poni_q   <= 1'b0;
      cur_lvl  <= LVL_NONE;
      new_lvl  <= LVL_NONE;
      old_lvl  <= LVL_NONE;
      PILKL    <= 1'b0;
      lchg_req <= 1'b0;
      busy     <= 1'b0;
    end else if (MCL) begin
      state    <= IDLE;
      cnt      <= '0;
      dirty    <= 1'b0;
      poni_q   <= 1'b0;
      cur_lvl  <= LVL_NONE;
      new_lvl  <= LVL_NONE;
      old_lvl  <= LVL_NONE;
      PILKL    <= 1'b0;
      lchg_req <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      poni_q   <= PONI;
      PILKL    <= (state_nxt == SAMPLE);
      lchg_req <= (state_nxt == REQ);
      busy     <= (state_nxt != IDLE);

      // A write in the sampling cycle must survive the clear
      if (pid_pie_wr || poni_rise) begin
        dirty <= 1'b1;
      end else if (state == SAMPLE) begin
        dirty <= 1'b0;
      end

      // Settle counter: load on entry, reload on write, saturate at zero
      if (state == IDLE && state_nxt == SETTLE) begin
        cnt <= CNT_RELOAD;
      end else if (state == SETTLE) begin
        if (pid_pie_wr) begin
          cnt <= CNT_RELOAD;
        end else if (cnt != '0) begin
          cnt <= cnt - CNT_W'(1);
        end
      end

      if (state == SAMPLE) begin
        new_lvl <= PK;
      end

      if (state == CMP && state_nxt == REQ) begin
        old_lvl <= cur_lvl;
      end

      if (state == REQ && lchg_ack) begin
        cur_lvl <= new_lvl;
      end
    end
  end

endmodule

// File: tb/tb_int_level_seq.sv
// Directed bench for int_level_seq (SETTLE_CYC = 2).
module tb_int_level_seq;
  import nd_int_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             MCL;
  logic             PONI;
  logic [LVL_W-1:0] PK;
  logic             pid_pie_wr;
  logic             ibnd;
  logic             lchg_ack;
  logic             PILKL;
  logic             lchg_req;
  logic [LVL_W-1:0] new_lvl;
  logic [LVL_W-1:0] old_lvl;
  logic [LVL_W-1:0] cur_lvl;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int pilkl_cnt = 0;
  int snap;

  int_level_seq #(.SETTLE_CYC(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MCL        (MCL),
    .PONI       (PONI),
    .PK         (PK),
    .pid_pie_wr (pid_pie_wr),
    .ibnd       (ibnd),
    .lchg_ack   (lchg_ack),
    .PILKL      (PILKL),
    .lchg_req   (lchg_req),
    .new_lvl    (new_lvl),
    .old_lvl    (old_lvl),
    .cur_lvl    (cur_lvl),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count PILKL pulses (each high cycle is seen at the edge that ends it)
  always @(posedge clk) begin
    if (PILKL) pilkl_cnt <= pilkl_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int pl, input int rq,
                         input int nl, input int ol, input int cl, input int bz);
    chk({tag, "_pilkl"}, int'(PILKL), pl);
    chk({tag, "_req"},   int'(lchg_req), rq);
    chk({tag, "_new"},   int'(new_lvl), nl);
    chk({tag, "_old"},   int'(old_lvl), ol);
    chk({tag, "_cur"},   int'(cur_lvl), cl);
    chk({tag, "_busy"},  int'(busy), bz);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; MCL = 1'b0; PONI = 1'b1; PK = 4'd0;
    pid_pie_wr = 1'b0; ibnd = 1'b0; lchg_ack = 1'b0;
    ticks(2);
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // ibnd gating: PONI seen rising after reset marks dirty, but no boundary yet
    PK = 4'd3;
    ticks(5);
    chk("ibnd_hold_busy", int'(busy), 0);
    chk("ibnd_hold_pilkl", pilkl_cnt, 0);
    ibnd = 1'b1;
    tick();
    chk("a_settle_busy", int'(busy), 1);
    chk("a_settle_pilkl", int'(PILKL), 0);
    ibnd = 1'b0;
    tick();
    tick();
    chk("a_sample_pilkl", int'(PILKL), 1);
    tick();
    chk_all("a_cmp", 0, 0, 3, 0, 0, 1);
    tick();
    chk_all("a_req", 0, 1, 3, 0, 0, 1);
    lchg_ack = 1'b1;
    tick();
    lchg_ack = 1'b0;
    chk_all("a_ack", 0, 0, 3, 0, 3, 0);

    // Request 3->5, then asynchronous reset while the request is pending
    ibnd = 1'b1; PK = 4'd5; pid_pie_wr = 1'b1;
    tick();
    pid_pie_wr = 1'b0;
    ticks(3);
    chk("b_sample_pilkl", int'(PILKL), 1);
    ticks(2);
    chk_all("b_req", 0, 1, 5, 3, 3, 1);
    #2;
    rst_n = 1'b0; PONI = 1'b0;
    #1;
    chk_all("b_async_rst", 0, 0, 0, 0, 0, 0);
    snap = pilkl_cnt;
    tick();
    rst_n = 1'b1;
    ticks(4);
    chk("b_post_rst_busy", int'(busy), 0);
    chk("b_post_rst_pilkl", pilkl_cnt - snap, 0);

    // PONI off: writes do not sample; PONI on then runs the request 0->5
    pid_pie_wr = 1'b1;
    tick();
    pid_pie_wr = 1'b0;
    ticks(3);
    pid_pie_wr = 1'b1;
    tick();
    pid_pie_wr = 1'b0;
    ticks(3);
    chk("c_off_busy", int'(busy), 0);
    chk("c_off_pilkl", pilkl_cnt - snap, 0);
    PONI = 1'b1;
    tick();
    chk("c_settle_busy", int'(busy), 1);
    ticks(2);
    chk("c_sample_pilkl", int'(PILKL), 1);
    ticks(2);
    chk_all("c_req", 0, 1, 5, 0, 0, 1);
    lchg_ack = 1'b1;
    tick();
    lchg_ack = 1'b0;
    chk_all("c_ack", 0, 0, 5, 0, 5, 0);

    // No change: PK equals cur_lvl, one PILKL and no request
    snap = pilkl_cnt;
    pid_pie_wr = 1'b1;
    tick();
    pid_pie_wr = 1'b0;
    ticks(3);
    chk("d_sample_pilkl", int'(PILKL), 1);
    tick();
    chk("d_cmp_req", int'(lchg_req), 0);
    tick();
    chk_all("d_idle", 0, 0, 5, 0, 5, 0);
    ticks(3);
    chk("d_pilkl_count", pilkl_cnt - snap, 1);
    chk("d_still_idle", int'(busy), 0);

    // Settle restart: second write in SETTLE pushes the sample out
    snap = pilkl_cnt;
    PK = 4'd7; pid_pie_wr = 1'b1;
    tick();
    pid_pie_wr = 1'b0;
    tick();
    chk("e_settle_busy", int'(busy), 1);
    pid_pie_wr = 1'b1;
    tick();
    pid_pie_wr = 1'b0;
    tick();
    chk("e_delayed_pilkl", int'(PILKL), 0);
    tick();
    chk("e_sample_pilkl", int'(PILKL), 1);
    ticks(2);
    chk_all("e_req", 0, 1, 7, 5, 5, 1);
    chk("e_pilkl_count", pilkl_cnt - snap, 1);
    lchg_ack = 1'b1;
    tick();
    lchg_ack = 1'b0;
    chk("e_ack_cur", int'(cur_lvl), 7);
    ticks(3);
    chk("e_dirty_cleared", int'(busy), 0);

    // Write during REQ: 7->5 completes first, then 5->10
    PK = 4'd5; pid_pie_wr = 1'b1;
    tick();
    pid_pie_wr = 1'b0;
    ticks(5);
    chk_all("f_req1", 0, 1, 5, 7, 7, 1);
    PK = 4'd10; pid_pie_wr = 1'b1; PONI = 1'b0;
    tick();
    pid_pie_wr = 1'b0; PONI = 1'b1;
    chk_all("f_req1_hold", 0, 1, 5, 7, 7, 1);
    lchg_ack = 1'b1;
    tick();
    lchg_ack = 1'b0;
    chk_all("f_ack1", 0, 0, 5, 7, 5, 0);
    ticks(3);
    chk("f_sample2_pilkl", int'(PILKL), 1);
    ticks(2);
    chk_all("f_req2", 0, 1, 10, 5, 5, 1);
    lchg_ack = 1'b1;
    tick();
    lchg_ack = 1'b0;
    chk("f_ack2_cur", int'(cur_lvl), 10);

    // Master clear behaves like reset
    ibnd = 1'b0;
    MCL = 1'b1;
    tick();
    MCL = 1'b0;
    chk_all("mcl", 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
